axis_uart_frame_decoder: RTL and testbench



---
 rtl/axis_uart_frame_decoder.sv | 251 +++++++++++++++++++++++++
 tb/tb_axis_uart_frame_decoder.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_uart_frame_decoder.sv
// Decodes framed packets (SOF, LEN, payload, XOR checksum) from the UART RX
// AXI-stream. Each received word is split into characters, and the payload
// is emitted as a byte-wide AXI-stream. tlast and the bad-frame flag (tuser)
// are attached to the final payload byte.
//
// Ports:
//   aclk, areset    clock, synchronous active-high reset
//   s_axis_*        packed characters from the transceiver; lane 0 arrives first
//   rx_error        transceiver parity/framing error pulse (any nonzero = error)
//   m_axis_*        payload characters; tuser is meaningful only with tlast
//   frame_ok_cnt    good frames, saturating
//   frame_err_cnt   bad frames plus illegal-LEN rejects, saturating
module axis_uart_frame_decoder #(
  parameter int unsigned AXI_DATA_WIDTH = 32,
  parameter int unsigned DATA_BITS      = 8,
  parameter int unsigned MAX_LEN        = 64,
  parameter int unsigned SOF            = 32'h7E
) (
  input  logic                      aclk,
  input  logic                      areset,
  input  logic [AXI_DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                      s_axis_tvalid,
  output logic                      s_axis_tready,
  input  logic [1:0]                rx_error,
  output logic [DATA_BITS-1:0]      m_axis_tdata,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready,
  output logic                      m_axis_tlast,
  output logic                      m_axis_tuser,
  output logic [15:0]               frame_ok_cnt,
  output logic [15:0]               frame_err_cnt
);

  localparam int unsigned LANES  = AXI_DATA_WIDTH / DATA_BITS;
  localparam int unsigned LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int unsigned CNT_W  = 16;

  localparam logic [LANE_W-1:0]    LAST_LANE = LANE_W'(LANES - 1);
  localparam logic [DATA_BITS-1:0] SOF_B     = DATA_BITS'(SOF);
  localparam logic [DATA_BITS-1:0] MAX_B     = DATA_BITS'(MAX_LEN);
  localparam logic [CNT_W-1:0]     CNT_MAX   = '1;

  typedef enum logic [1:0] {
    ST_HUNT,
    ST_LEN,
    ST_PAYLOAD,
    ST_CHECK
  } state_e;

  state_e                    state_q, state_d;

  // Unpacker
  logic [AXI_DATA_WIDTH-1:0] word_q, word_d;
  logic                      full_q, full_d;
  logic [LANE_W-1:0]         lane_q, lane_d;

  // Frame context
  logic [DATA_BITS-1:0]      cnt_q, cnt_d;
  logic [DATA_BITS-1:0]      xor_q, xor_d;
  logic                      err_q, err_d;

  // One-deep holdback so tlast/tuser can join the final payload byte
  logic                      pend_vld_q, pend_vld_d;
  logic [DATA_BITS-1:0]      pend_q, pend_d;

  // Output register
  logic                      out_vld_q, out_vld_d;
  logic [DATA_BITS-1:0]      out_data_q, out_data_d;
  logic                      out_last_q, out_last_d;
  logic                      out_user_q, out_user_d;

  logic [CNT_W-1:0]          ok_cnt_q, ok_cnt_d;
  logic [CNT_W-1:0]          err_cnt_q, err_cnt_d;

  logic [DATA_BITS-1:0]      cur_byte_c;
  logic                      out_free_c;
  logic                      byte_acc_c;
  logic                      s_tready_c;
  logic                      word_acc_c;
  logic                      rx_err_c;
  logic                      bad_c;

  // Lane select for the character currently presented by the unpacker
  always_comb begin
    cur_byte_c = '0;
    for (int i = 0; i < LANES; i++) begin
      if (lane_q == LANE_W'(i)) begin
        cur_byte_c = word_q[i*DATA_BITS +: DATA_BITS];
      end
    end
  end

  // A byte can move only when the output register is free this cycle
  always_comb begin
    out_free_c = !out_vld_q || m_axis_tready;
    byte_acc_c = full_q && out_free_c;
    s_tready_c = !areset && (!full_q || (byte_acc_c && (lane_q == LAST_LANE)));
    word_acc_c = s_axis_tvalid && s_tready_c;
    rx_err_c   = |rx_error;
  end

  // Unpacker next state: refill on word acceptance, else step through lanes
  always_comb begin
    word_d = word_q;
    full_d = full_q;
    lane_d = lane_q;
    if (byte_acc_c) begin
      if (lane_q == LAST_LANE) begin
        full_d = 1'b0;
      end else begin
        lane_d = lane_q + LANE_W'(1);
      end
    end
    if (word_acc_c) begin
      word_d = s_axis_tdata;
      full_d = 1'b1;
      lane_d = '0;
    end
  end

  // Frame FSM, holdback and output register next state
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    xor_d      = xor_q;
    err_d      = err_q;
    pend_vld_d = pend_vld_q;
    pend_d     = pend_q;
    out_vld_d  = out_vld_q;
    out_data_d = out_data_q;
    out_last_d = out_last_q;
    out_user_d = out_user_q;
    ok_cnt_d   = ok_cnt_q;
    err_cnt_d  = err_cnt_q;
    bad_c      = 1'b0;

    if (out_vld_q && m_axis_tready) begin
      out_vld_d = 1'b0;
    end

    // Transceiver errors taint the frame anywhere past SOF
    if ((state_q != ST_HUNT) && rx_err_c) begin
      err_d = 1'b1;
    end

    case (state_q)
      ST_HUNT: begin
        if (byte_acc_c && (cur_byte_c == SOF_B)) begin
          err_d   = 1'b0;
          state_d = ST_LEN;
        end
      end

      ST_LEN: begin
        if (byte_acc_c) begin
          if ((cur_byte_c == '0) || (cur_byte_c > MAX_B)) begin
            err_cnt_d = (err_cnt_q == CNT_MAX) ? err_cnt_q : err_cnt_q + CNT_W'(1);
            state_d   = ST_HUNT;
          end else begin
            cnt_d   = cur_byte_c;
            xor_d   = cur_byte_c;
            state_d = ST_PAYLOAD;
          end
        end
      end

      ST_PAYLOAD: begin
        if (byte_acc_c) begin
          xor_d = xor_q ^ cur_byte_c;
          cnt_d = cnt_q - DATA_BITS'(1);
          if (pend_vld_q) begin
            out_vld_d  = 1'b1;
            out_data_d = pend_q;
            out_last_d = 1'b0;
            out_user_d = 1'b0;
          end
          pend_d     = cur_byte_c;
          pend_vld_d = 1'b1;
          if (cnt_q == DATA_BITS'(1)) begin
            state_d = ST_CHECK;
          end
        end
      end

      ST_CHECK: begin
        if (byte_acc_c) begin
          bad_c      = err_q || rx_err_c || (xor_q != cur_byte_c);
          out_vld_d  = 1'b1;
          out_data_d = pend_q;
          out_last_d = 1'b1;
          out_user_d = bad_c;
          pend_vld_d = 1'b0;
          if (bad_c) begin
            err_cnt_d = (err_cnt_q == CNT_MAX) ? err_cnt_q : err_cnt_q + CNT_W'(1);
          end else begin
            ok_cnt_d = (ok_cnt_q == CNT_MAX) ? ok_cnt_q : ok_cnt_q + CNT_W'(1);
          end
          state_d = ST_HUNT;
        end
      end

      default: state_d = ST_HUNT;
    endcase
  end

  // State registers
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q    <= ST_HUNT;
      word_q     <= '0;
      full_q     <= 1'b0;
      lane_q     <= '0;
      cnt_q      <= '0;
      xor_q      <= '0;
      err_q      <= 1'b0;
      pend_vld_q <= 1'b0;
      pend_q     <= '0;
      out_vld_q  <= 1'b0;
      out_data_q <= '0;
      out_last_q <= 1'b0;
      out_user_q <= 1'b0;
      ok_cnt_q   <= '0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      word_q     <= word_d;
      full_q     <= full_d;
      lane_q     <= lane_d;
      cnt_q      <= cnt_d;
      xor_q      <= xor_d;
      err_q      <= err_d;
      pend_vld_q <= pend_vld_d;
      pend_q     <= pend_d;
      out_vld_q  <= out_vld_d;
      out_data_q <= out_data_d;
      out_last_q <= out_last_d;
      out_user_q <= out_user_d;
      ok_cnt_q   <= ok_cnt_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign s_axis_tready = s_tready_c;
  assign m_axis_tdata  = out_data_q;
  assign m_axis_tvalid = out_vld_q;
  assign m_axis_tlast  = out_last_q;
  assign m_axis_tuser  = out_user_q;
  assign frame_ok_cnt  = ok_cnt_q;
  assign frame_err_cnt = err_cnt_q;

endmodule

// File: tb/tb_axis_uart_frame_decoder.sv
// Directed bench for axis_uart_frame_decoder with hand-computed frames.
module tb_axis_uart_frame_decoder;

  typedef logic [7:0] byte_q_t[$];

  logic        aclk = 1'b0;
  logic        areset;
  logic [31:0] s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic [1:0]  rx_error;
  logic [7:0]  m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tlast;
  logic        m_axis_tuser;
  logic [15:0] frame_ok_cnt;
  logic [15:0] frame_err_cnt;

  int tests = 0;
  int fails = 0;

  // Captured output handshakes: {tlast, tuser, tdata}
  logic [9:0] cap[$];

  axis_uart_frame_decoder #(
    .AXI_DATA_WIDTH(32),
    .DATA_BITS     (8),
    .MAX_LEN       (64),
    .SOF           (32'h7E)
  ) dut (
    .aclk         (aclk),
    .areset       (areset),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .rx_error     (rx_error),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tlast (m_axis_tlast),
    .m_axis_tuser (m_axis_tuser),
    .frame_ok_cnt (frame_ok_cnt),
    .frame_err_cnt(frame_err_cnt)
  );

  always #5 aclk = ~aclk;

  always @(posedge aclk) begin
    if (!areset && m_axis_tvalid && m_axis_tready) begin
      cap.push_back({m_axis_tlast, m_axis_tuser, m_axis_tdata});
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called just after a posedge; returns just after the accepting posedge
  task automatic send_word(input logic [31:0] w);
    int  n;
    logic hs;
    n  = 0;
    hs = 1'b0;
    s_axis_tdata  = w;
    s_axis_tvalid = 1'b1;
    do begin
      @(negedge aclk);
      hs = s_axis_tready;
      @(posedge aclk);
      n++;
    end while (!hs && n < 500);
    #1;
    s_axis_tvalid = 1'b0;
    check("send_handshake", 32'(hs), 32'd1);
  endtask

  task automatic do_reset();
    areset        = 1'b1;
    s_axis_tvalid = 1'b0;
    rx_error      = 2'b00;
    repeat (2) @(posedge aclk);
    #1;
    areset = 1'b0;
    cap.delete();
  endtask

  task automatic drain();
    repeat (20) @(posedge aclk);
    #1;
  endtask

  task automatic expect_frame(input string tag, input byte_q_t e, input logic user);
    check({tag, "_count"}, 32'(cap.size()), 32'(e.size()));
    for (int i = 0; i < e.size(); i++) begin
      logic       last;
      logic [9:0] exp_v;
      logic [9:0] got;
      last  = (i == e.size() - 1);
      exp_v = {last, last & user, e[i]};
      got   = (i < cap.size()) ? cap[i] : 10'h3FF;
      check(tag, 32'(got), 32'(exp_v));
    end
    cap.delete();
  endtask

  initial begin
    byte_q_t e;
    int      n;
    int      stable;
    int      nlast;
    logic [7:0] first;

    areset        = 1'b1;
    s_axis_tdata  = 32'h0;
    s_axis_tvalid = 1'b0;
    rx_error      = 2'b00;
    m_axis_tready = 1'b1;

    // Reset state
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    check("rst_tready",  32'(s_axis_tready), 32'd0);
    check("rst_tvalid",  32'(m_axis_tvalid), 32'd0);
    check("rst_tdata",   32'(m_axis_tdata),  32'd0);
    check("rst_tlast",   32'(m_axis_tlast),  32'd0);
    check("rst_tuser",   32'(m_axis_tuser),  32'd0);
    check("rst_ok_cnt",  32'(frame_ok_cnt),  32'd0);
    check("rst_err_cnt", 32'(frame_err_cnt), 32'd0);
    @(posedge aclk);
    #1;
    areset = 1'b0;
    cap.delete();

    // Good frame: 7E 03 11 22 33 03 00 00
    send_word(32'h2211037E);
    send_word(32'h00000333);
    drain();
    e = {8'h11, 8'h22, 8'h33};
    expect_frame("good", e, 1'b0);
    check("good_ok_cnt",  32'(frame_ok_cnt),  32'd1);
    check("good_err_cnt", 32'(frame_err_cnt), 32'd0);

    // Bad checksum 04
    do_reset();
    send_word(32'h2211037E);
    send_word(32'h00000433);
    drain();
    e = {8'h11, 8'h22, 8'h33};
    expect_frame("badcks", e, 1'b1);
    check("badcks_ok_cnt",  32'(frame_ok_cnt),  32'd0);
    check("badcks_err_cnt", 32'(frame_err_cnt), 32'd1);

    // Illegal LEN: 7E 00, 7E 41, then the good frame
    do_reset();
    send_word(32'h417E007E);
    drain();
    check("badlen_no_out", 32'(cap.size()), 32'd0);
    check("badlen_err_cnt", 32'(frame_err_cnt), 32'd2);
    send_word(32'h2211037E);
    send_word(32'h00000333);
    drain();
    e = {8'h11, 8'h22, 8'h33};
    expect_frame("badlen_good", e, 1'b0);
    check("badlen_ok_cnt",  32'(frame_ok_cnt),  32'd1);
    check("badlen_err_cnt2", 32'(frame_err_cnt), 32'd2);

    // Backpressure: 7E 08 01..08 cks=00, sink stalled after first output
    do_reset();
    m_axis_tready = 1'b0;
    fork
      begin
        send_word(32'h0201087E);
        send_word(32'h06050403);
        send_word(32'h00000807);
      end
      begin
        n = 0;
        do begin
          @(negedge aclk);
          n++;
        end while (!m_axis_tvalid && n < 200);
        check("bp_first_valid", 32'(m_axis_tvalid), 32'd1);
        first = m_axis_tdata;
        check("bp_first_data", 32'(first), 32'h01);
        stable = 0;
        repeat (20) begin
          @(negedge aclk);
          if (m_axis_tvalid && (m_axis_tdata == first) && !m_axis_tlast) stable++;
        end
        check("bp_stable", 32'(stable), 32'd20);
        check("bp_s_tready_low", 32'(s_axis_tready), 32'd0);
        @(posedge aclk);
        #1;
        m_axis_tready = 1'b1;
      end
    join
    drain();
    e = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    expect_frame("bp", e, 1'b0);
    check("bp_ok_cnt", 32'(frame_ok_cnt), 32'd1);

    // rx_error: ignored in HUNT, taints frame during payload
    do_reset();
    rx_error = 2'b01;
    @(posedge aclk);
    #1;
    rx_error = 2'b00;
    send_word(32'h2211037E);
    send_word(32'h00000333);
    drain();
    e = {8'h11, 8'h22, 8'h33};
    expect_frame("rxerr_hunt", e, 1'b0);
    check("rxerr_hunt_ok",  32'(frame_ok_cnt),  32'd1);
    check("rxerr_hunt_err", 32'(frame_err_cnt), 32'd0);
    send_word(32'h2211037E);
    repeat (2) @(posedge aclk);
    #1;
    rx_error = 2'b01;
    @(posedge aclk);
    #1;
    rx_error = 2'b00;
    send_word(32'h00000333);
    drain();
    e = {8'h11, 8'h22, 8'h33};
    expect_frame("rxerr_pay", e, 1'b1);
    check("rxerr_pay_ok",  32'(frame_ok_cnt),  32'd1);
    check("rxerr_pay_err", 32'(frame_err_cnt), 32'd1);

    // Reset after two payload bytes, counters nonzero beforehand
    send_word(32'h2211037E);
    repeat (4) @(posedge aclk);
    #1;
    areset = 1'b1;
    @(posedge aclk);
    #1;
    check("mid_tready",  32'(s_axis_tready), 32'd0);
    check("mid_tvalid",  32'(m_axis_tvalid), 32'd0);
    check("mid_tdata",   32'(m_axis_tdata),  32'd0);
    check("mid_tlast",   32'(m_axis_tlast),  32'd0);
    check("mid_tuser",   32'(m_axis_tuser),  32'd0);
    check("mid_ok_cnt",  32'(frame_ok_cnt),  32'd0);
    check("mid_err_cnt", 32'(frame_err_cnt), 32'd0);
    areset = 1'b0;
    nlast = 0;
    foreach (cap[i]) if (cap[i][9]) nlast++;
    check("mid_no_tlast", 32'(nlast), 32'd0);
    cap.delete();
    send_word(32'h2211037E);
    send_word(32'h00000333);
    drain();
    e = {8'h11, 8'h22, 8'h33};
    expect_frame("mid_good", e, 1'b0);
    check("mid_good_ok",  32'(frame_ok_cnt),  32'd1);
    check("mid_good_err", 32'(frame_err_cnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
